// File: rtl/pcie_ss_ctrl_responder.sv
// pcie_ss_ctrl_responder: software-level CSR command to subsystem AVMM master bridge
//
// Turns a level-held software command (idle/write/read/reserved) into a single
// AVMM transaction and reports completion through a level ack that stays high
// until software returns the command to idle.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_ss_ctrl_cmd          00 idle, 01 write, 10 read, 11 reserved (error)
//   i_ss_ctrl_addr         CSR byte address, latched on acceptance
//   i_ss_ctrl_writedata    write data, latched on acceptance
//   o_ss_readdata          last read result (held across writes and errors)
//   o_ss_ack, o_ss_error   command complete / command failed
//   o_avmm_*               subsystem master request
//   i_avmm_*               subsystem master response
//
// Optional feature: define PCIE_SS_CTRL_TIMEOUT_EN to abort a stalled bus
// access after TIMEOUT_CYCLES cycles (error set, reads return all ones).

package ofs_fim_cfg_pkg;
    localparam int PCIE_LITE_CSR_WIDTH = 20;
endpackage

module pcie_ss_ctrl_responder #(
    parameter int ADDR_WIDTH     = ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_ss_ctrl_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ss_ctrl_addr,
    input  logic [31:0]           i_ss_ctrl_writedata,
    output logic [31:0]           o_ss_readdata,
    output logic                  o_ss_ack,
    output logic                  o_ss_error,
    output logic [ADDR_WIDTH-1:0] o_avmm_address,
    output logic                  o_avmm_write,
    output logic                  o_avmm_read,
    output logic [31:0]           o_avmm_writedata,
    input  logic                  i_avmm_waitrequest,
    input  logic [31:0]           i_avmm_readdata,
    input  logic                  i_avmm_readdatavalid
);
    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT, DONE} state_t;

    if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 4");
    end

    state_t                state_q;
    logic [31:0]           readdata_q;
    logic                  ack_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic                  read_q;
    logic [31:0]           wdata_q;
    logic                  timeout;

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            readdata_q <= '0;
            ack_q      <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            wdata_q    <= '0;
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
            // Runs only while a bus access is outstanding; zero on entry from IDLE.
            cnt_q <= (state_q == WR_REQ || state_q == RD_REQ || state_q == RD_WAIT) ? cnt_q + 1'b1 : '0;
`endif
            case (state_q)
                IDLE: begin
                    if (i_ss_ctrl_cmd == 2'b01) begin
                        addr_q  <= i_ss_ctrl_addr;
                        wdata_q <= i_ss_ctrl_writedata;
                        error_q <= 1'b0;
                        write_q <= 1'b1;
                        state_q <= WR_REQ;
                    end else if (i_ss_ctrl_cmd == 2'b10) begin
                        addr_q  <= i_ss_ctrl_addr;
                        error_q <= 1'b0;
                        read_q  <= 1'b1;
                        state_q <= RD_REQ;
                    end else if (i_ss_ctrl_cmd == 2'b11) begin
                        error_q <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                WR_REQ: begin
                    if (!i_avmm_waitrequest || timeout) begin
                        write_q <= 1'b0;
                        error_q <= i_avmm_waitrequest;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RD_REQ: begin
                    if (!i_avmm_waitrequest) begin
                        read_q <= 1'b0;
                        if (i_avmm_readdatavalid) begin
                            readdata_q <= i_avmm_readdata;
                            ack_q      <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= RD_WAIT;
`ifdef PCIE_SS_CTRL_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end else if (timeout) begin
                        read_q     <= 1'b0;
                        error_q    <= 1'b1;
                        readdata_q <= '1;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                RD_WAIT: begin
                    if (i_avmm_readdatavalid) begin
                        readdata_q <= i_avmm_readdata;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end else if (timeout) begin
                        error_q    <= 1'b1;
                        readdata_q <= '1;
                        ack_q      <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // Level ack: software must drop cmd to idle before a new command.
                    if (i_ss_ctrl_cmd == 2'b00) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ss_readdata    = readdata_q;
    assign o_ss_ack         = ack_q;
    assign o_ss_error       = error_q;
    assign o_avmm_address   = addr_q;
    assign o_avmm_write     = write_q;
    assign o_avmm_read      = read_q;
    assign o_avmm_writedata = wdata_q;
endmodule

// File: tb/tb_pcie_ss_ctrl_responder.sv
// tb_pcie_ss_ctrl_responder: directed and randomized check of the CSR command responder
module tb_pcie_ss_ctrl_responder;
    localparam int AW = 20;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic          waitreq = 1'b0;
    logic          rdv = 1'b0;
    logic [31:0]   rdata = '0;
    logic [31:0]   o_ss_readdata;
    logic          o_ss_ack;
    logic          o_ss_error;
    logic [AW-1:0] o_avmm_address;
    logic          o_avmm_write;
    logic          o_avmm_read;
    logic [31:0]   o_avmm_writedata;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_rd = '0;

    always #5 clk = ~clk;

    pcie_ss_ctrl_responder #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_ss_ctrl_cmd        (cmd),
        .i_ss_ctrl_addr       (addr),
        .i_ss_ctrl_writedata  (wdata),
        .o_ss_readdata        (o_ss_readdata),
        .o_ss_ack             (o_ss_ack),
        .o_ss_error           (o_ss_error),
        .o_avmm_address       (o_avmm_address),
        .o_avmm_write         (o_avmm_write),
        .o_avmm_read          (o_avmm_read),
        .o_avmm_writedata     (o_avmm_writedata),
        .i_avmm_waitrequest   (waitreq),
        .i_avmm_readdata      (rdata),
        .i_avmm_readdatavalid (rdv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(o_ss_ack), 0);
        chk({tag, "_err"}, 32'(o_ss_error), 0);
        chk({tag, "_rdata"}, o_ss_readdata, 0);
        chk({tag, "_rd"}, 32'(o_avmm_read), 0);
        chk({tag, "_wr"}, 32'(o_avmm_write), 0);
        chk({tag, "_addr"}, 32'(o_avmm_address), 0);
        chk({tag, "_wdata"}, o_avmm_writedata, 0);
    endtask

    // One software command. w = cycles of waitrequest before acceptance,
    // dl = cycles from acceptance to readdatavalid, hold = extra cycles cmd stays non-zero after ack.
    task automatic run_txn(input logic [1:0] c, input logic [AW-1:0] a, input logic [31:0] d,
                           input int w, input int dl, input logic [31:0] rd, input int hold);
        bit is_wr = (c == 2'b01);
        bit is_rd = (c == 2'b10);
        int lat = is_rd ? w + 2 + dl : (is_wr ? w + 2 : 1);
        int pulses = 0;
        int bad = 0;
        int ackbad = 0;
        int both = 0;
        @(negedge clk);
        cmd = c; addr = a; wdata = d; waitreq = 1'b0; rdv = 1'b0;
        for (int k = 1; k <= lat + hold; k++) begin
            @(negedge clk);
            if (o_avmm_write || o_avmm_read) begin
                pulses++;
                if (o_avmm_address !== a || (o_avmm_write && (!is_wr || o_avmm_writedata !== d)) || (o_avmm_read && !is_rd))
                    bad++;
            end
            if (o_avmm_write && o_avmm_read) both++;
            if (k == lat) begin
                if (is_rd) exp_rd = rd;
                chk("ack_rise", 32'(o_ss_ack), 1);
                chk("error", 32'(o_ss_error), 32'(c == 2'b11));
                chk("readdata", o_ss_readdata, exp_rd);
            end else if (o_ss_ack !== (k > lat)) ackbad++;
            cmd = 2'($urandom_range(1, 3));
            addr = AW'($urandom);
            wdata = $urandom;
            rdata = $urandom;
            waitreq = (k <= w) ? 1'b1 : (k >= lat ? 1'($urandom) : 1'b0);
            if (is_rd && k < lat) begin
                rdv = (k == 1 + w + dl);
                if (rdv) rdata = rd;
            end else rdv = 1'($urandom);
        end
        cmd = 2'b00;
        @(negedge clk);
        rdv = 1'b0; waitreq = 1'b0;
        chk("ack_fall", 32'(o_ss_ack), 0);
        chk("readdata_hold", o_ss_readdata, exp_rd);
        chk("pulse_cycles", pulses, (is_wr || is_rd) ? w + 1 : 0);
        chk("req_fields", bad, 0);
        chk("ack_level", ackbad, 0);
        chk("rd_wr_overlap", both, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_txn(2'b01, AW'('h100), 32'hA5A5_0001, 0, 0, 0, 0);
        run_txn(2'b10, AW'('h40), 32'h0, 3, 2, 32'h1234_5678, 0);
        run_txn(2'b10, AW'('h44), 32'h0, 0, 1, 32'hCAFE_0003, 0);
        run_txn(2'b10, AW'('h48), 32'h0, 0, 0, 32'h0BAD_F00D, 1);
        run_txn(2'b11, AW'('h10), 32'h0, 0, 0, 32'h0, 2);
        run_txn(2'b01, AW'('h104), 32'h5A5A_0002, 1, 0, 32'h0, 0);
        run_txn(2'b01, AW'('h108), 32'h0000_0041, 0, 0, 32'h0, 50);

        for (int i = 0; i < 25; i++)
            run_txn(2'($urandom_range(1, 3)), AW'($urandom), $urandom, int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), $urandom, int'($urandom_range(0, 3)));

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
        begin
            int rd_cycles = 0;
            @(negedge clk);
            cmd = 2'b10; addr = AW'('h80); waitreq = 1'b1;
            for (int k = 1; k <= TO + 1; k++) begin
                @(negedge clk);
                if (o_avmm_read) rd_cycles++;
                if (k == TO + 1) begin
                    chk("to_ack", 32'(o_ss_ack), 1);
                    chk("to_err", 32'(o_ss_error), 1);
                    chk("to_rdata", o_ss_readdata, 32'hFFFF_FFFF);
                end
            end
            chk("to_read_cycles", rd_cycles, TO);
            exp_rd = 32'hFFFF_FFFF;
            cmd = 2'b00; waitreq = 1'b0;
            @(negedge clk);
            chk("to_ack_fall", 32'(o_ss_ack), 0);
        end
`endif

        @(negedge clk);
        cmd = 2'b10; addr = AW'('h60); waitreq = 1'b0; rdv = 1'b0;
        @(negedge clk);
        chk("mid_rd_req", 32'(o_avmm_read), 1);
        @(negedge clk);
        chk("mid_rd_wait", 32'(o_avmm_read), 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        cmd = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        rdv = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rdv = 1'b0;
        @(negedge clk);
        exp_rd = '0;
        chk("stray_rdv_rdata", o_ss_readdata, exp_rd);
        chk("stray_rdv_ack", 32'(o_ss_ack), 0);

        rst_n = 1'b0; cmd = 2'b01; addr = AW'('h200); wdata = 32'h7777_0001;
        @(negedge clk);
        chk("held_in_reset_wr", 32'(o_avmm_write), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_wr", 32'(o_avmm_write), 1);
        chk("post_reset_addr", 32'(o_avmm_address), 32'h200);
        @(negedge clk);
        chk("post_reset_ack", 32'(o_ss_ack), 1);
        cmd = 2'b00;
        @(negedge clk);
        chk("post_reset_ack_fall", 32'(o_ss_ack), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pcie_ss_ctrl_responder.md
PCIE_SS_CTRL_RESPONDER -- requirements
Module: pcie_ss_ctrl_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH, is the width of the subsystem CSR byte address.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, is the bus-access timeout limit in clk cycles (min 4).
REQ-003 clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-005 i_ss_ctrl_cmd  input  2  is the command: 00 idle, 01 write, 10 read, 11 reserved; it is a level held by software.
REQ-006 i_ss_ctrl_addr  input  ADDR_WIDTH  is the target CSR byte address.
REQ-007 i_ss_ctrl_writedata  input  32  is the write data.
REQ-008 o_ss_readdata  output  32  is the last read result.
REQ-009 o_ss_ack  output  1  indicates the command is complete.
REQ-010 o_ss_error  output  1  indicates the command failed, due to a reserved command or a timeout.
REQ-011 o_avmm_address  output  ADDR_WIDTH, o_avmm_write  output  1, o_avmm_read  output  1 and o_avmm_writedata  output  32 form the subsystem master request.
REQ-012 i_avmm_waitrequest  input  1, i_avmm_readdata  input  32 and i_avmm_readdatavalid  input  1 form the subsystem master response.

Function
REQ-013 The FSM SHALL have five states: IDLE, WR_REQ, RD_REQ, RD_WAIT and DONE.
REQ-014 In IDLE, when cmd = 01 the FSM SHALL latch addr and writedata, clear o_ss_error and move to WR_REQ.
REQ-015 In IDLE, when cmd = 10 the FSM SHALL latch addr, clear o_ss_error and move to RD_REQ.
REQ-016 In IDLE, when cmd = 11 the FSM SHALL set o_ss_error, perform no bus access and move to DONE.
REQ-017 In WR_REQ, o_avmm_write SHALL be 1 with the latched address and data; when waitrequest = 0 the FSM SHALL move to DONE.
REQ-018 In RD_REQ, o_avmm_read SHALL be 1; when waitrequest = 0 the FSM SHALL move to RD_WAIT.
REQ-019 If readdatavalid is also 1 in that RD_REQ cycle, the FSM SHALL capture the data and go directly to DONE.
REQ-020 In RD_WAIT, when readdatavalid = 1 the FSM SHALL register i_avmm_readdata into o_ss_readdata and move to DONE.
REQ-021 In DONE, o_ss_ack SHALL be 1; when cmd = 00 the FSM SHALL return to IDLE, and o_ss_ack SHALL be 0 from the next cycle.
REQ-022 Latency: with waitrequest = 0, o_ss_ack SHALL rise 2 cycles after the cycle cmd = 01 is first sampled in IDLE.
REQ-023 Latency: for a read with readdatavalid 1 cycle after acceptance, o_ss_ack SHALL rise 3 cycles after that sample.
REQ-024 Changes to cmd, addr or writedata outside IDLE SHALL be ignored; the latched values are used.
REQ-025 A cmd held non-zero after DONE SHALL NOT retrigger; software must return cmd to 00 first.
REQ-026 readdatavalid outside RD_REQ and RD_WAIT SHALL be ignored.
REQ-027 o_ss_readdata SHALL hold its value across writes and errored commands until the next successful read completes.
REQ-028 o_avmm_read and o_avmm_write SHALL never be 1 simultaneously.
REQ-029 Both SHALL be 0 in IDLE and DONE.

Reset
REQ-030 Asserting rst_n low, including mid-operation, SHALL immediately force IDLE.
REQ-031 Reset SHALL force o_ss_ack = 0, o_ss_error = 0, o_ss_readdata = 0, o_avmm_read = 0, o_avmm_write = 0, o_avmm_address = 0, o_avmm_writedata = 0, and clear the timeout counter.
REQ-032 After reset release, a cmd still at 01 or 10 SHALL be accepted as a new command.

Configuration
REQ-033 Macro PCIE_SS_CTRL_TIMEOUT_EN defined: a counter SHALL run in WR_REQ, RD_REQ and RD_WAIT and clear on each state entry.
REQ-034 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 without completion, the FSM SHALL drop read/write, set o_ss_error, set o_ss_readdata = 32'hFFFF_FFFF on reads, and move to DONE.
REQ-035 Macro PCIE_SS_CTRL_TIMEOUT_EN undefined: no counter SHALL exist, the FSM SHALL wait indefinitely, and o_ss_error SHALL be set only by cmd = 11.

Verification
REQ-036 Write: cmd = 01, addr = 'h100, data = 32'hA5A5_0001, waitrequest = 0 -> one-cycle write at 'h100 with that data; ack = 1 two cycles later; ack = 0 one cycle after cmd = 00.
REQ-037 Read: cmd = 10, addr = 'h40, waitrequest high 3 cycles, readdatavalid 2 cycles after acceptance with 32'h1234_5678 -> read held 4 cycles; readdata = 32'h1234_5678, ack = 1, error = 0.
REQ-038 Reserved: cmd = 11 -> no read/write pulses; ack = 1, error = 1; then a cmd = 00 and cmd = 01 sequence clears error on acceptance.
REQ-039 Timeout (macro defined, TIMEOUT_CYCLES = 16): read with waitrequest stuck at 1 -> read drops after 16 cycles; error = 1, readdata = 32'hFFFF_FFFF, ack = 1.
REQ-040 Reset mid-read: rst_n low while in RD_WAIT -> all outputs 0 immediately; a later stray readdatavalid does not change readdata.
REQ-041 No retrigger: cmd held at 01 for 50 cycles after ack -> exactly one write pulse is issued.
